// File: rtl/cosim_pkg.sv
// Shared encodings for the OOO-vs-ISA lockstep co-simulation controller.
package cosim_pkg;

  typedef logic [1:0] cosim_state_t;
  typedef logic [1:0] cosim_fail_t;

  localparam cosim_state_t S_INIT = 2'd0;
  localparam cosim_state_t S_RUN  = 2'd1;
  localparam cosim_state_t S_PASS = 2'd2;
  localparam cosim_state_t S_FAIL = 2'd3;

  localparam cosim_fail_t FC_NONE = 2'd0;
  localparam cosim_fail_t FC_INIT = 2'd1;
  localparam cosim_fail_t FC_STEP = 2'd2;
  localparam cosim_fail_t FC_HANG = 2'd3;

  localparam int unsigned DEF_STALL_LIMIT = 10;

  function automatic logic is_terminal(cosim_state_t s);
    return (s == S_PASS) || (s == S_FAIL);
  endfunction

endpackage

// File: rtl/cosim_step_ctrl_if.sv
// Signal bundle between the co-sim environment (master) and the step controller (slave).
interface cosim_step_ctrl_if #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned STALL_W = 4
);
  logic               dut_commit;
  logic               same_state;
  logic               same_step;
  logic               ref_step;
  logic               check_valid;
  logic [CNT_W-1:0]   commit_cnt;
  logic [CNT_W-1:0]   check_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [1:0]         state;
  logic [1:0]         fail_code;
  logic               done;

  modport master (
    output dut_commit, same_state, same_step,
    input  ref_step, check_valid, commit_cnt, check_cnt, stall_cnt, state, fail_code, done
  );

  modport slave (
    input  dut_commit, same_state, same_step,
    output ref_step, check_valid, commit_cnt, check_cnt, stall_cnt, state, fail_code, done
  );
endinterface

// File: rtl/cosim_watchdog.sv
// Saturating commit-free cycle counter; hit flags the edge that completes a hang.
module cosim_watchdog #(
  parameter int unsigned LIMIT = 10,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         hit
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign hit = en && !clr && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cosim_step_ctrl.sv
// Lockstep sequencer: steps the ISA model once per OOO commit, checks state one cycle later,
// and latches a sticky pass/fail verdict.
module cosim_step_ctrl
  import cosim_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int unsigned STALL_W     = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_CHECKS  = 0
) (
  input logic              clk,
  input logic              rst,
  cosim_step_ctrl_if.slave bus
);

  cosim_state_t     state_q, state_d;
  cosim_fail_t      fail_code_q, fail_code_d;
  logic             ref_step_q, ref_step_d;
  logic             check_valid_q, check_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
  logic             active, check_ok, check_bad, hang_hit;
  logic [STALL_W-1:0] stall_cnt;

  assign active    = (state_q == S_INIT) || (state_q == S_RUN);
  assign check_ok  = check_valid_q && bus.same_step;
  assign check_bad = check_valid_q && !bus.same_step;

  cosim_watchdog #(
    .LIMIT (STALL_LIMIT),
    .W     (STALL_W)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .en  (active),
    .clr (bus.dut_commit),
    .cnt (stall_cnt),
    .hit (hang_hit)
  );

  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    ref_step_d    = 1'b0;
    check_valid_d = 1'b0;
    commit_cnt_d  = commit_cnt_q;
    check_cnt_d   = check_cnt_q;

    if (active) begin
      ref_step_d    = bus.dut_commit;
      check_valid_d = ref_step_q;
      if (bus.dut_commit && (commit_cnt_q != '1)) begin
        commit_cnt_d = commit_cnt_q + CNT_W'(1);
      end
      if (check_ok && (check_cnt_q != '1)) begin
        check_cnt_d = check_cnt_q + CNT_W'(1);
      end

      // Verdict priority: INIT > STEP > HANG > PASS.
      if ((state_q == S_INIT) && !bus.same_state) begin
        state_d     = S_FAIL;
        fail_code_d = FC_INIT;
      end else if (check_bad) begin
        state_d     = S_FAIL;
        fail_code_d = FC_STEP;
      end else if (hang_hit) begin
        state_d     = S_FAIL;
        fail_code_d = FC_HANG;
      end else if ((MAX_CHECKS != 0) && check_ok && (check_cnt_d == CNT_W'(MAX_CHECKS))) begin
        state_d = S_PASS;
      end else begin
        state_d = S_RUN;
      end

      // Squash in-flight steps and checks as soon as the verdict is latched.
      if (is_terminal(state_d)) begin
        ref_step_d    = 1'b0;
        check_valid_d = 1'b0;
      end
    end

    done_d = is_terminal(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      fail_code_q   <= FC_NONE;
      ref_step_q    <= 1'b0;
      check_valid_q <= 1'b0;
      done_q        <= 1'b0;
      commit_cnt_q  <= '0;
      check_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      ref_step_q    <= ref_step_d;
      check_valid_q <= check_valid_d;
      done_q        <= done_d;
      commit_cnt_q  <= commit_cnt_d;
      check_cnt_q   <= check_cnt_d;
    end
  end

  assign bus.ref_step    = ref_step_q;
  assign bus.check_valid = check_valid_q;
  assign bus.commit_cnt  = commit_cnt_q;
  assign bus.check_cnt   = check_cnt_q;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.state       = state_q;
  assign bus.fail_code   = fail_code_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_cosim_step_ctrl.sv
// Bench for cosim_step_ctrl: directed scenarios plus randomized runs against a cycle-level model.
module tb_cosim_step_ctrl;
  import cosim_pkg::*;

  localparam int unsigned LIMIT = 10;
  localparam int unsigned CW    = 16;
  localparam int unsigned SW    = 4;
  localparam int          MAX1  = 4;

  typedef struct packed {
    logic [1:0]    state;
    logic [1:0]    fail_code;
    logic          ref_step;
    logic          check_valid;
    logic          done;
    logic [CW-1:0] commit_cnt;
    logic [CW-1:0] check_cnt;
    logic [SW-1:0] stall_cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit = 1'b0;
  logic sstate = 1'b1;
  logic sstep = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  cosim_step_ctrl_if #(.CNT_W(CW), .STALL_W(SW)) bus0 ();
  cosim_step_ctrl_if #(.CNT_W(CW), .STALL_W(SW)) bus1 ();

  assign bus0.dut_commit = commit;
  assign bus0.same_state = sstate;
  assign bus0.same_step  = sstep;
  assign bus1.dut_commit = commit;
  assign bus1.same_state = sstate;
  assign bus1.same_step  = sstep;

  cosim_step_ctrl #(.STALL_LIMIT(LIMIT), .STALL_W(SW), .CNT_W(CW), .MAX_CHECKS(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  cosim_step_ctrl #(.STALL_LIMIT(LIMIT), .STALL_W(SW), .CNT_W(CW), .MAX_CHECKS(MAX1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  obs_t obs[2];
  assign obs[0] = {bus0.state, bus0.fail_code, bus0.ref_step, bus0.check_valid, bus0.done,
                   bus0.commit_cnt, bus0.check_cnt, bus0.stall_cnt};
  assign obs[1] = {bus1.state, bus1.fail_code, bus1.ref_step, bus1.check_valid, bus1.done,
                   bus1.commit_cnt, bus1.check_cnt, bus1.stall_cnt};

  always #5 clk = ~clk;

  // Reference model: one entry per instance; m_acc records cycles whose commit was accepted.
  logic [1:0] m_state[2];
  logic [1:0] m_fail[2];
  int         m_commits[2];
  int         m_checks[2];
  int         m_idle[2];
  bit         m_acc[2][0:1023];
  int         cyc;

  function automatic bit m_alive(int k);
    return (m_state[k] == S_INIT) || (m_state[k] == S_RUN);
  endfunction

  function automatic bit m_committed(int k, int c);
    return (c >= 0) && (c < 1024) && m_acc[k][c];
  endfunction

  function automatic obs_t model_obs(int k);
    obs_t e;
    e = '0;
    e.state       = m_state[k];
    e.fail_code   = m_fail[k];
    e.ref_step    = m_alive(k) && m_committed(k, cyc - 1);
    e.check_valid = m_alive(k) && m_committed(k, cyc - 2);
    e.done        = !m_alive(k);
    e.commit_cnt  = CW'(m_commits[k]);
    e.check_cnt   = CW'(m_checks[k]);
    e.stall_cnt   = SW'(m_idle[k]);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = S_INIT; m_fail[k] = FC_NONE;
      m_commits[k] = 0; m_checks[k] = 0; m_idle[k] = 0;
      for (int c = 0; c < 1024; c++) m_acc[k][c] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit chk, hang;
      int maxc;
      if (!m_alive(k)) continue;
      maxc = (k == 1) ? MAX1 : 0;
      chk  = m_committed(k, cyc - 2);
      hang = !commit && (m_idle[k] == int'(LIMIT) - 1);
      if (commit) begin
        if (cyc < 1024) m_acc[k][cyc] = 1'b1;
        if (m_commits[k] < 65535) m_commits[k]++;
        m_idle[k] = 0;
      end else if (m_idle[k] < 15) begin
        m_idle[k]++;
      end
      if (chk && sstep && m_checks[k] < 65535) m_checks[k]++;
      if (m_state[k] == S_INIT && !sstate) begin
        m_state[k] = S_FAIL; m_fail[k] = FC_INIT;
      end else if (chk && !sstep) begin
        m_state[k] = S_FAIL; m_fail[k] = FC_STEP;
      end else if (hang) begin
        m_state[k] = S_FAIL; m_fail[k] = FC_HANG;
      end else if (maxc != 0 && chk && sstep && m_checks[k] == maxc) begin
        m_state[k] = S_PASS;
      end else begin
        m_state[k] = S_RUN;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; commit = 1'b0; sstate = 1'b1; sstep = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t exp;
    exp = '0;
    exp.state = S_INIT;
    exp.fail_code = FC_NONE;
    rst = 1'b1; commit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp) begin
          miscompares++;
          $display("FAIL reset_hold dut%0d got %h want %h", k, obs[k], exp);
        end
      end
    end
    commit = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs[k] !== exp) begin
        miscompares++;
        $display("FAIL reset_release dut%0d got %h want %h", k, obs[k], exp);
      end
    end
  endtask

  task automatic test_commit_pipeline();
    logic [7:0] got_ref, got_chk;
    do_reset(2);
    for (int c = 0; c < 8; c++) begin
      got_ref[c] = bus0.ref_step;
      got_chk[c] = bus0.check_valid;
      commit = (c >= 1 && c <= 3);
      tick();
    end
    commit = 1'b0;
    vectors++;
    if (got_ref !== 8'b0001_1100) begin
      miscompares++;
      $display("FAIL pipe_ref_step got %b want %b", got_ref, 8'b0001_1100);
    end
    vectors++;
    if (got_chk !== 8'b0011_1000) begin
      miscompares++;
      $display("FAIL pipe_check_valid got %b want %b", got_chk, 8'b0011_1000);
    end
    vectors++;
    if (bus0.commit_cnt !== 16'd3 || bus0.check_cnt !== 16'd3 || bus0.state !== S_RUN) begin
      miscompares++;
      $display("FAIL pipe_counts got c=%0d k=%0d s=%0d want 3 3 %0d",
               bus0.commit_cnt, bus0.check_cnt, bus0.state, S_RUN);
    end
  endtask

  task automatic test_init_fail();
    logic any_ref;
    do_reset(1);
    sstate = 1'b0;
    tick();
    sstate = 1'b1;
    vectors++;
    if (bus0.state !== S_FAIL || bus0.fail_code !== FC_INIT || bus0.done !== 1'b1) begin
      miscompares++;
      $display("FAIL init_mismatch got s=%0d f=%0d d=%0b want %0d %0d 1",
               bus0.state, bus0.fail_code, bus0.done, S_FAIL, FC_INIT);
    end
    any_ref = 1'b0;
    commit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_ref |= bus0.ref_step | bus1.ref_step;
    end
    commit = 1'b0;
    vectors++;
    if (any_ref !== 1'b0 || bus0.commit_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL init_frozen got ref=%0b cnt=%0d want 0 0", any_ref, bus0.commit_cnt);
    end
  endtask

  task automatic test_step_fail();
    do_reset(1);
    tick();
    commit = 1'b1; tick();
    commit = 1'b1; tick();
    commit = 1'b0;
    vectors++;
    if (bus0.check_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL step_check_cycle got %0b want 1", bus0.check_valid);
    end
    sstep = 1'b0;
    tick();
    sstep = 1'b1;
    vectors++;
    if (bus0.state !== S_FAIL || bus0.fail_code !== FC_STEP || bus0.check_valid !== 1'b0 ||
        bus0.commit_cnt !== 16'd2 || bus0.check_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL step_mismatch got s=%0d f=%0d cv=%0b c=%0d k=%0d want %0d %0d 0 2 0",
               bus0.state, bus0.fail_code, bus0.check_valid, bus0.commit_cnt, bus0.check_cnt,
               S_FAIL, FC_STEP);
    end
  endtask

  task automatic test_hang();
    do_reset(1);
    for (int c = 0; c < 9; c++) tick();
    vectors++;
    if (bus0.state !== S_RUN || bus0.stall_cnt !== 4'd9) begin
      miscompares++;
      $display("FAIL hang_pre got s=%0d st=%0d want %0d 9", bus0.state, bus0.stall_cnt, S_RUN);
    end
    tick();
    vectors++;
    if (bus0.state !== S_FAIL || bus0.fail_code !== FC_HANG) begin
      miscompares++;
      $display("FAIL hang got s=%0d f=%0d want %0d %0d", bus0.state, bus0.fail_code,
               S_FAIL, FC_HANG);
    end
    do_reset(1);
    for (int c = 0; c < 9; c++) tick();
    commit = 1'b1; tick();
    commit = 1'b0;
    vectors++;
    if (bus0.state !== S_RUN || bus0.stall_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL hang_avoided got s=%0d st=%0d want %0d 0", bus0.state, bus0.stall_cnt,
               S_RUN);
    end
  endtask

  task automatic test_pass();
    for (int v = 0; v < 2; v++) begin
      do_reset(1);
      for (int c = 0; c < 14; c++) begin
        commit = (c == 1 || c == 4 || c == 7 || c == 10 || c == 13);
        sstep  = !(v == 1 && c == 12);
        tick();
      end
      commit = 1'b0; sstep = 1'b1;
      vectors++;
      if (v == 0) begin
        if (bus1.state !== S_PASS || bus1.done !== 1'b1 || bus1.commit_cnt !== 16'd4 ||
            bus1.check_cnt !== 16'd4) begin
          miscompares++;
          $display("FAIL pass got s=%0d d=%0b c=%0d k=%0d want %0d 1 4 4",
                   bus1.state, bus1.done, bus1.commit_cnt, bus1.check_cnt, S_PASS);
        end
      end else begin
        if (bus1.state !== S_FAIL || bus1.fail_code !== FC_STEP) begin
          miscompares++;
          $display("FAIL pass_vs_step got s=%0d f=%0d want %0d %0d",
                   bus1.state, bus1.fail_code, S_FAIL, FC_STEP);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    tick();
    commit = 1'b1; tick();
    commit = 1'b0; tick();
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (obs[0] !== obs_t'(0)) begin
      miscompares++;
      $display("FAIL mid_reset got %h want %h", obs[0], obs_t'(0));
    end
    rst = 1'b0;
    model_reset();
    tick();
    vectors++;
    if (bus0.state !== S_RUN || bus0.check_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_rerun got s=%0d cv=%0b want %0d 0", bus0.state,
               bus0.check_valid, S_RUN);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 40; run++) begin
      int idle_left;
      idle_left = 0;
      do_reset(1 + int'($urandom % 3));
      for (int c = 0; c < 80; c++) begin
        for (int k = 0; k < 2; k++) begin
          obs_t exp;
          exp = model_obs(k);
          vectors++;
          if (obs[k] !== exp) begin
            miscompares++;
            $display("FAIL random run%0d cyc%0d dut%0d got %h want %h", run, c, k, obs[k], exp);
          end
        end
        if ($urandom % 120 == 0) break;
        if (idle_left == 0 && $urandom % 20 == 0) idle_left = int'($urandom_range(6, 12));
        if (idle_left > 0) begin
          commit = 1'b0;
          idle_left--;
        end else begin
          commit = ($urandom % 3 != 0);
        end
        sstate = (c == 0) ? ($urandom % 8 != 0) : 1'($urandom % 2);
        sstep  = ($urandom % 25 != 0);
        tick();
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit_pipeline();
    test_init_fail();
    test_step_fail();
    test_hang();
    test_pass();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
